// File: rtl/vid_timing_gen.sv
// vid_timing_gen: runtime-reprogrammable raster timing generator.
// An active timing set drives the sx/sy counters. A shadow set holds one
// pending configuration, which is copied into the active set on the edge
// that wraps the raster from (htot-1, vtot-1) back to (0,0), so a mode
// switch never tears a frame. All outputs are registered and describe the
// same pixel in the same cycle.
module vid_timing_gen #(
  parameter int               CORDW    = 12,
  parameter logic [4*CORDW-1:0] DEF_HTIM = {12'd640, 12'd16, 12'd96, 12'd48},
  parameter logic [4*CORDW-1:0] DEF_VTIM = {12'd480, 12'd10, 12'd2, 12'd33},
  parameter logic [1:0]       DEF_POL  = 2'b00
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [4*CORDW-1:0] cfg_htim,
  input  logic [4*CORDW-1:0] cfg_vtim,
  input  logic [1:0]         cfg_pol,
  output logic               cfg_err,
  output logic [CORDW-1:0]   sx,
  output logic [CORDW-1:0]   sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  localparam int TW = 4 * CORDW;
  localparam int SW = CORDW + 2;

  // Field idx: 3 = active, 2 = front porch, 1 = sync, 0 = back porch,
  // zero-extended to the sum width so totals cannot overflow.
  function automatic logic [SW-1:0] fld_f(input logic [TW-1:0] t, input int idx);
    return {2'b00, t[idx*CORDW +: CORDW]};
  endfunction

  function automatic logic [SW-1:0] tot_f(input logic [TW-1:0] t);
    return fld_f(t, 3) + fld_f(t, 2) + fld_f(t, 1) + fld_f(t, 0);
  endfunction

  // A timing set is usable when no field is zero and the total fits the counter.
  function automatic logic ok_f(input logic [TW-1:0] t);
    logic [SW-1:0] max_tot;
    max_tot = {2'b01, {CORDW{1'b0}}};
    return (fld_f(t, 3) != {SW{1'b0}}) && (fld_f(t, 2) != {SW{1'b0}}) &&
           (fld_f(t, 1) != {SW{1'b0}}) && (fld_f(t, 0) != {SW{1'b0}}) &&
           (tot_f(t) <= max_tot);
  endfunction

  // True while pos lies inside [act+fp, act+fp+sync).
  function automatic logic sync_f(input logic [CORDW-1:0] pos, input logic [TW-1:0] t);
    logic [SW-1:0] s0;
    logic [SW-1:0] s1;
    logic [SW-1:0] p;
    s0 = fld_f(t, 3) + fld_f(t, 2);
    s1 = s0 + fld_f(t, 1);
    p  = {2'b00, pos};
    return (p >= s0) && (p < s1);
  endfunction

  localparam logic [SW-1:0]    ONE_S     = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [CORDW-1:0] ZERO_C    = {CORDW{1'b0}};
  localparam logic [CORDW-1:0] ONE_C     = {{(CORDW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]    DEF_HLAST = tot_f(DEF_HTIM) - ONE_S;
  localparam logic [SW-1:0]    DEF_VLAST = tot_f(DEF_VTIM) - ONE_S;
  localparam logic [CORDW-1:0] RST_SX    = DEF_HLAST[CORDW-1:0];
  localparam logic [CORDW-1:0] RST_SY    = DEF_VLAST[CORDW-1:0];

  logic [TW-1:0]    htim_q, htim_d, vtim_q, vtim_d;
  logic [1:0]       pol_q, pol_d;
  logic [TW-1:0]    sh_htim_q, sh_htim_d, sh_vtim_q, sh_vtim_d;
  logic [1:0]       sh_pol_q, sh_pol_d;
  logic             pending_q, pending_d;
  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic             line_q, line_d, frame_q, frame_d, err_q, err_d;

  logic [SW-1:0]    htot_s, vtot_s;
  logic             h_last_s, v_last_s, wrap_s, cfg_ok_s;

  // Next-state: counters, frame-wrap swap, config capture/reject, next-pixel outputs.
  always_comb begin
    htot_s    = tot_f(htim_q);
    vtot_s    = tot_f(vtim_q);
    h_last_s  = ({2'b00, sx_q} == (htot_s - ONE_S));
    v_last_s  = ({2'b00, sy_q} == (vtot_s - ONE_S));
    wrap_s    = h_last_s && v_last_s;
    cfg_ok_s  = ok_f(cfg_htim) && ok_f(cfg_vtim);

    htim_d    = htim_q;
    vtim_d    = vtim_q;
    pol_d     = pol_q;
    sh_htim_d = sh_htim_q;
    sh_vtim_d = sh_vtim_q;
    sh_pol_d  = sh_pol_q;
    pending_d = pending_q;
    err_d     = 1'b0;

    if (h_last_s) begin
      sx_d = ZERO_C;
      if (v_last_s) begin
        sy_d = ZERO_C;
      end else begin
        sy_d = sy_q + ONE_C;
      end
    end else begin
      sx_d = sx_q + ONE_C;
      sy_d = sy_q;
    end

    // The pending set takes over exactly as the new frame begins.
    if (wrap_s && pending_q) begin
      htim_d    = sh_htim_q;
      vtim_d    = sh_vtim_q;
      pol_d     = sh_pol_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    // Offers are only looked at while nothing is pending; a capture here
    // never collides with the swap above because that needs pending set.
    if (cfg_valid && !pending_q) begin
      if (cfg_ok_s) begin
        sh_htim_d = cfg_htim;
        sh_vtim_d = cfg_vtim;
        sh_pol_d  = cfg_pol;
        pending_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end

    // Outputs for the pixel about to be shown use the timing it belongs to.
    de_d    = ({2'b00, sx_d} < fld_f(htim_d, 3)) && ({2'b00, sy_d} < fld_f(vtim_d, 3));
    hsync_d = sync_f(sx_d, htim_d) ? pol_d[1] : ~pol_d[1];
    vsync_d = sync_f(sy_d, vtim_d) ? pol_d[0] : ~pol_d[0];
    line_d  = (sx_d == ZERO_C);
    frame_d = (sx_d == ZERO_C) && (sy_d == ZERO_C);
  end

  // State and output registers; reset parks the raster on the last default pixel.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      htim_q    <= DEF_HTIM;
      vtim_q    <= DEF_VTIM;
      pol_q     <= DEF_POL;
      sh_htim_q <= DEF_HTIM;
      sh_vtim_q <= DEF_VTIM;
      sh_pol_q  <= DEF_POL;
      pending_q <= 1'b0;
      sx_q      <= RST_SX;
      sy_q      <= RST_SY;
      de_q      <= 1'b0;
      hsync_q   <= ~DEF_POL[1];
      vsync_q   <= ~DEF_POL[0];
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      htim_q    <= htim_d;
      vtim_q    <= vtim_d;
      pol_q     <= pol_d;
      sh_htim_q <= sh_htim_d;
      sh_vtim_q <= sh_vtim_d;
      sh_pol_q  <= sh_pol_d;
      pending_q <= pending_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready   = ~pending_q;
  assign cfg_err     = err_q;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: directed and random stimulus for vid_timing_gen,
// checked every cycle against a frame-position reference model.
// Small default timings keep every frame short.
module tb_vid_timing_gen;

  localparam int          CORDW = 12;
  localparam logic [47:0] DEF_H = {12'd20, 12'd2, 12'd3, 12'd4};   // htot 29
  localparam logic [47:0] DEF_V = {12'd10, 12'd1, 12'd2, 12'd3};   // vtot 16
  localparam logic [1:0]  DEF_P = 2'b01;

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [47:0] cfg_htim = 48'd0;
  logic [47:0] cfg_vtim = 48'd0;
  logic [1:0]  cfg_pol = 2'b00;
  logic        cfg_ready, cfg_err, hsync, vsync, de, line_start, frame_start;
  logic [11:0] sx, sy;

  vid_timing_gen #(.CORDW(CORDW), .DEF_HTIM(DEF_H), .DEF_VTIM(DEF_V), .DEF_POL(DEF_P)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_htim(cfg_htim), .cfg_vtim(cfg_vtim), .cfg_pol(cfg_pol), .cfg_err(cfg_err),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start));

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  // Reference model: active/shadow timing and the linear pixel index in the frame.
  logic [47:0] m_h, m_v, s_h, s_v;
  logic [1:0]  m_pol, s_pol;
  bit          m_pend, m_err;
  int          p;

  function automatic int fld(logic [47:0] t, int i);
    return int'(t[i*12 +: 12]);
  endfunction

  function automatic int tot(logic [47:0] t);
    return fld(t, 3) + fld(t, 2) + fld(t, 1) + fld(t, 0);
  endfunction

  function automatic bit ok(logic [47:0] t);
    return fld(t, 3) > 0 && fld(t, 2) > 0 && fld(t, 1) > 0 && fld(t, 0) > 0 && tot(t) <= 4096;
  endfunction

  function automatic int last_p();
    return tot(m_h) * tot(m_v) - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_h = DEF_H; m_v = DEF_V; m_pol = DEF_P;
    s_h = DEF_H; s_v = DEF_V; s_pol = DEF_P;
    m_pend = 1'b0; m_err = 1'b0;
    p = tot(DEF_H) * tot(DEF_V) - 1;
  endtask

  task automatic check_model();
    int ht, x, y, ha, hs0, hs1, va, vs0, vs1;
    ht  = tot(m_h);
    x   = p % ht;
    y   = p / ht;
    ha  = fld(m_h, 3); hs0 = ha + fld(m_h, 2); hs1 = hs0 + fld(m_h, 1);
    va  = fld(m_v, 3); vs0 = va + fld(m_v, 2); vs1 = vs0 + fld(m_v, 1);
    chk("sx", sx, x);
    chk("sy", sy, y);
    chk("de", de, (x < ha) && (y < va));
    chk("hsync", hsync, (x >= hs0 && x < hs1) ? m_pol[1] : !m_pol[1]);
    chk("vsync", vsync, (y >= vs0 && y < vs1) ? m_pol[0] : !m_pol[0]);
    chk("line_start", line_start, x == 0);
    chk("frame_start", frame_start, p == 0);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("cfg_err", cfg_err, m_err);
  endtask

  // One clock: sample the offered inputs, advance the model across the edge, compare.
  task automatic tick();
    logic        v;
    logic [47:0] h, vv;
    logic [1:0]  pl;
    bit          was_pend;
    int          lp;
    v = cfg_valid; h = cfg_htim; vv = cfg_vtim; pl = cfg_pol;
    @(posedge clk_pix);
    lp = last_p();
    was_pend = m_pend;
    m_err = 1'b0;
    if (v && !was_pend) begin
      if (ok(h) && ok(vv)) begin
        s_h = h; s_v = vv; s_pol = pl; m_pend = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (p == lp) begin
      p = 0;
      if (was_pend) begin
        m_h = s_h; m_v = s_v; m_pol = s_pol; m_pend = 1'b0;
      end
    end else begin
      p++;
    end
    #1;
    check_model();
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (p != target && n < 40000);
    chk("run_to_reached", p, target);
  endtask

  task automatic offer(input logic [47:0] h, input logic [47:0] v, input logic [1:0] pl);
    cfg_valid = 1'b1; cfg_htim = h; cfg_vtim = v; cfg_pol = pl;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_sx"}, sx, tot(DEF_H) - 1);
    chk({tag, "_sy"}, sy, tot(DEF_V) - 1);
    chk({tag, "_de"}, de, 1'b0);
    chk({tag, "_hsync"}, hsync, !DEF_P[1]);
    chk({tag, "_vsync"}, vsync, !DEF_P[0]);
    chk({tag, "_line"}, line_start, 1'b0);
    chk({tag, "_frame"}, frame_start, 1'b0);
    chk({tag, "_err"}, cfg_err, 1'b0);
    chk({tag, "_ready"}, cfg_ready, 1'b1);
  endtask

  // Assert reset between edges, check without an edge, hold across one edge, release.
  task automatic apply_reset(input string tag);
    cfg_valid = 1'b0;
    rst_pix = 1'b1;
    #1;
    model_reset();
    reset_check({tag, "_async"});
    @(posedge clk_pix);
    #1;
    reset_check({tag, "_held"});
    #2 rst_pix = 1'b0;
  endtask

  task automatic first_pixel_check(input string tag);
    tick();
    chk({tag, "_sx0"}, sx, 12'd0);
    chk({tag, "_sy0"}, sy, 12'd0);
    chk({tag, "_fs"}, frame_start, 1'b1);
    chk({tag, "_ls"}, line_start, 1'b1);
    chk({tag, "_de"}, de, 1'b1);
  endtask

  function automatic logic [47:0] rnd_tim(input int amax, input int pmax);
    logic [47:0] t;
    t[47:36] = 12'($urandom_range(amax, 1));
    t[35:24] = 12'($urandom_range(pmax, 1));
    t[23:12] = 12'($urandom_range(pmax, 1));
    t[11:0]  = 12'($urandom_range(pmax, 1));
    return t;
  endfunction

  localparam logic [47:0] A_H = {12'd24, 12'd3, 12'd4, 12'd5};    // 36
  localparam logic [47:0] A_V = {12'd12, 12'd2, 12'd3, 12'd4};    // 21
  localparam logic [47:0] B_H = {12'd16, 12'd1, 12'd2, 12'd3};    // 22
  localparam logic [47:0] B_V = {12'd8, 12'd1, 12'd1, 12'd2};     // 12
  localparam logic [47:0] C_H = {12'd10, 12'd1, 12'd1, 12'd1};    // 13
  localparam logic [47:0] C_V = {12'd5, 12'd1, 12'd1, 12'd1};     // 8
  localparam logic [47:0] BIG_H = {12'd4093, 12'd1, 12'd1, 12'd1}; // 4096
  localparam logic [47:0] MIN_V = {12'd1, 12'd1, 12'd1, 12'd1};   // 4
  localparam logic [47:0] NOSYNC_H = {12'd20, 12'd2, 12'd0, 12'd4};
  localparam logic [47:0] OVER_H = {12'd4000, 12'd50, 12'd40, 12'd7}; // 4097

  initial begin
    logic [47:0] rh, rv;
    int          fi;

    #1;
    apply_reset("reset");
    first_pixel_check("release");

    // A full default frame.
    run_to(0);

    // Mode switch offered mid-frame.
    run_to(5 * tot(m_h));
    offer(A_H, A_V, 2'b11);
    chk("switch_ready_low", cfg_ready, 1'b0);
    run_to(0);
    chk("switch_ready_back", cfg_ready, 1'b1);
    run_to(0);

    // Offer landing on the wrap edge itself.
    run_to(last_p());
    offer(B_H, B_V, 2'b10);
    chk("wrap_sx", sx, 12'd0);
    chk("wrap_ready_low", cfg_ready, 1'b0);
    run_to(0);
    run_to(0);

    // Rejected offers.
    offer(NOSYNC_H, C_V, 2'b00);
    chk("rej_sync_err", cfg_err, 1'b1);
    chk("rej_sync_ready", cfg_ready, 1'b1);
    tick();
    offer(OVER_H, C_V, 2'b00);
    chk("rej_htot_err", cfg_err, 1'b1);
    offer(C_H, OVER_H, 2'b00);
    chk("rej_vtot_err", cfg_err, 1'b1);
    tick();

    // Back-pressure: second offer while one is pending.
    offer(C_H, C_V, 2'b00);
    cfg_valid = 1'b1; cfg_htim = A_H; cfg_vtim = A_V; cfg_pol = 2'b11;
    repeat (3) begin
      tick();
      chk("bp_no_err", cfg_err, 1'b0);
    end
    cfg_valid = 1'b0;
    run_to(0);
    run_to(0);

    // Largest legal line length, then back to a short mode.
    offer(BIG_H, MIN_V, 2'b01);
    run_to(0);
    offer(C_H, C_V, 2'b10);
    run_to(0);

    // Asynchronous reset mid-frame with a config pending.
    offer(A_H, A_V, 2'b11);
    run_to(7);
    chk("pre_reset_pending", cfg_ready, 1'b0);
    apply_reset("midreset");
    first_pixel_check("midrelease");
    run_to(0);

    // Random offers, including invalid ones and offers while pending.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(24, 0) == 0) begin
        rh = rnd_tim(30, 5);
        rv = rnd_tim(12, 3);
        if ($urandom_range(5, 0) == 0) begin
          fi = int'($urandom_range(3, 0));
          if ($urandom_range(1, 0) == 0) rh[fi*12 +: 12] = 12'd0;
          else rv[fi*12 +: 12] = 12'd0;
        end
        cfg_valid = 1'b1; cfg_htim = rh; cfg_vtim = rv; cfg_pol = 2'($urandom_range(3, 0));
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
    end
    cfg_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Runtime-reprogrammable raster timing generator, the parametrised successor to the fixed per-resolution screen-position counter. It produces pixel coordinates, sync, data-enable, and line/frame strobes for any timing that fits in a CORDW-bit counter. It accepts a new timing set over a valid/ready config port and applies it only at a frame boundary, so mode switches never tear a frame. It sits at the head of the pixel pipeline in the clk_pix domain, feeding the pattern/framebuffer readers and the TMDS/VGA output stage.

## Interface
- CORDW, 12, width of sx/sy and of every timing field; every total must satisfy 1 ≤ total ≤ 2**CORDW.
- DEF_HTIM, {640,16,96,48} (each CORDW bits, MSB first: active, front porch, sync, back porch), horizontal timing loaded at reset.
- DEF_VTIM, {480,10,2,33}, vertical timing loaded at reset, same packing.
- DEF_POL, 2'b00, {hpol,vpol} loaded at reset; 1 = active-high sync, 0 = active-low.
- clk_pix  in  1  pixel clock; sole clock.
- rst_pix  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  new timing offered.
- cfg_ready  out  1  high when no config is pending.
- cfg_htim  in  4*CORDW  {act,fp,sync,bp} horizontal.
- cfg_vtim  in  4*CORDW  {act,fp,sync,bp} vertical.
- cfg_pol  in  2  {hpol,vpol}.
- cfg_err  out  1  one-cycle pulse: offered config rejected.
- sx  out  CORDW  current column, 0 to htot-1.
- sy  out  CORDW  current line, 0 to vtot-1.
- hsync  out  1  horizontal sync, polarity per active hpol.
- vsync  out  1  vertical sync, polarity per active vpol.
- de  out  1  high when sx < h_act and sy < v_act.
- line_start  out  1  high while sx == 0.
- frame_start  out  1  high while sx == 0 and sy == 0.

## Operation
- Two register sets hold timing and polarity: **active** drives the counters; **shadow** holds one pending config. A `pending` flag tracks the shadow. cfg_ready = !pending.
- htot = act+fp+sync+bp. vtot is formed the same way. Both sums use CORDW+2 bits.
- **Accept:** cfg_valid && cfg_ready with all eight fields nonzero, htot ≤ 2**CORDW, and vtot ≤ 2**CORDW. The block captures the config into shadow and sets pending.
- **Reject:** cfg_valid && cfg_ready with any field zero or any total out of range. The block pulses cfg_err for one cycle, captures nothing, and leaves pending at 0.
- cfg_valid while !cfg_ready is ignored: no capture and no cfg_err. The source holds the config until ready.
- **Counters:** sx increments every cycle. At sx == htot-1, sx wraps to 0 and sy increments. At sy == vtot-1, sy wraps to 0.
- **Frame wrap:** the edge that moves the counters from (htot-1, vtot-1) to (0,0). On this edge:
  - If pending was 1 before the edge, active ← shadow and pending ← 0.
  - The new frame runs entirely on the new timing.
- A config accepted on the frame-wrap edge itself is not applied at that wrap. It is applied at the following wrap.
- hsync is asserted (at active hpol) when act+fp ≤ sx < act+fp+sync. vsync uses the same rule on sy with the v fields.

## Timing
- All outputs are registered and describe the same pixel in the same cycle. There is no skew between sx/sy and de/syncs/strobes.
- Reset (asynchronous) sets:
  - active ← DEF_*, shadow ← DEF_*, pending 0.
  - sx = htot-1 and sy = vtot-1 of the default timing.
  - de 0, hsync/vsync at their inactive level, line_start 0, frame_start 0, cfg_err 0, cfg_ready 1.
- The first clk_pix edge after rst_pix falls shows (0,0) with frame_start = line_start = de = 1.
- Reset asserted mid-frame or with a config pending discards the pending config and returns to the reset state immediately, without waiting for a clock edge.
- cfg_ready falls the cycle after acceptance. It rises on the cycle that shows (0,0) of the frame using the new timing.
- cfg_err appears the cycle after the rejected offer.

## Test plan
- **Default run:** release reset, run 2 frames. Expect frame_start every 420000 cycles and line_start every 800. hsync is low exactly for sx 656–751, vsync low for sy 490–491, and de covers 640×480.
- **Mode switch mid-frame:** at sy=200, offer {1280,110,40,220}/{720,5,5,20}, pol 2'b11. Expect cfg_ready=0 and the rest of the frame unchanged at 800×525. The next frame runs 1650×750 with active-high syncs at sx 1390–1429 and sy 725–729, and cfg_ready returns to 1 at (0,0).
- **Offer on the wrap edge:** assert cfg_valid on the edge where the counters go to (0,0). The frame that starts on that edge still uses the old timing; the new timing starts at the next wrap.
- **Reject:** offer h sync = 0 → cfg_err pulses once, cfg_ready stays 1, timing unchanged. Offer htot = 2**CORDW+1 → same response.
- **Back-pressure:** with a config pending, offer a second config. Expect no capture and no cfg_err. After the wrap, the first config is active.
- **Async reset mid-frame:** assert rst_pix between edges at sx=300 with a config pending. Outputs reach reset values before the next edge, pending clears, and the first frame after release uses the 640×480 default timing.
